// File: rtl/icache_pkg.sv
// Shared instruction-cache definitions: geometry defaults, refill FSM states and
// fill-bus transaction types.
package icache_pkg;

    localparam int ICACHE_TAG_WIDTH = 20;
    localparam int ICACHE_IDX_WIDTH = 8;
    localparam int ICACHE_WAYS      = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_WRITE,
        ST_FLUSH
    } refill_state_t;

    typedef struct packed {
        logic [ICACHE_TAG_WIDTH-1:0] tag;
        logic [ICACHE_IDX_WIDTH-1:0] idx;
    } fill_req_t;

    typedef struct packed {
        logic valid;
        logic err;
    } fill_resp_t;

endpackage

// File: rtl/icache_victim_sel.sv
// Victim way choice: lowest invalid way wins, otherwise a round-robin pointer
// that only advances when it actually supplies the victim.
module icache_victim_sel
    import icache_pkg::*;
#(
    parameter int WAYS = ICACHE_WAYS
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [WAYS-1:0]           vbits_i,
    input  logic                      use_i,
    output logic [$clog2(WAYS)-1:0]   victim_o
);

    localparam int VW = $clog2(WAYS);

    logic [VW-1:0] rr_cnt;
    logic          all_valid;

    assign all_valid = &vbits_i;

    // Scan downwards so the lowest-numbered free way is the last (winning) assignment.
    always_comb begin
        victim_o = rr_cnt;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!vbits_i[i]) begin
                victim_o = VW'(i);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_cnt <= '0;
        end else if (use_i && all_valid) begin
            rr_cnt <= rr_cnt + VW'(1);
        end
    end

endmodule

// File: rtl/icache_refill_ctrl.sv
// I-cache line refill controller: issues one fill request per accepted miss,
// writes the returned tag into the victim way and sequences invalidate-all.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for a miss or flush request
// ST_REQ   | fill request presented, waiting for downstream ready
// ST_WAIT  | request accepted, waiting for the fill response
// ST_WRITE | one cycle: write captured tag into the victim way
// ST_FLUSH | one cycle: clear all valid bits
module icache_refill_ctrl
    import icache_pkg::*;
#(
    parameter int TAG_WIDTH = ICACHE_TAG_WIDTH,
    parameter int IDX_WIDTH = ICACHE_IDX_WIDTH,
    parameter int WAYS      = ICACHE_WAYS
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           miss_i,
    input  logic [TAG_WIDTH-1:0]           miss_tag_i,
    input  logic [IDX_WIDTH-1:0]           miss_idx_i,
    input  logic [WAYS-1:0]                way_vbits_i,
    input  logic                           flush_i,
    output logic                           fill_req_valid_o,
    input  logic                           fill_req_ready_i,
    output logic [TAG_WIDTH+IDX_WIDTH-1:0] fill_req_addr_o,
    input  logic                           fill_resp_valid_i,
    input  logic                           fill_resp_err_i,
    output logic [WAYS-1:0]                tag_req_o,
    output logic                           tag_we_o,
    output logic                           tag_vbit_o,
    output logic [TAG_WIDTH-1:0]           tag_data_o,
    output logic [IDX_WIDTH-1:0]           tag_addr_o,
    output logic                           tag_flush_o,
    output logic                           busy_o,
    output logic                           refill_done_o,
    output logic                           refill_err_o,
    output logic [$clog2(WAYS)-1:0]        victim_way_o
);

    localparam int VW = $clog2(WAYS);

    refill_state_t          state;
    logic                   flush_pending;
    logic [TAG_WIDTH-1:0]   cap_tag;
    logic [IDX_WIDTH-1:0]   cap_idx;
    logic [VW-1:0]          cap_victim;
    logic [VW-1:0]          sel_victim;
    logic [WAYS-1:0]        way_onehot;
    logic                   miss_take;
    logic                   flush_now;
    fill_resp_t             resp;

    assign resp       = '{valid: fill_resp_valid_i, err: fill_resp_err_i};
    assign miss_take  = (state == ST_IDLE) && miss_i && !flush_i;
    // A flush seen in the same cycle as a response already forbids the tag write.
    assign flush_now  = flush_pending || flush_i;
    assign way_onehot = WAYS'(1) << cap_victim;

    assign fill_req_addr_o = {cap_tag, cap_idx};
    assign tag_data_o      = cap_tag;
    assign tag_addr_o      = cap_idx;
    assign victim_way_o    = cap_victim;

    icache_victim_sel #(
        .WAYS(WAYS)
    ) u_victim_sel (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .vbits_i  (way_vbits_i),
        .use_i    (miss_take),
        .victim_o (sel_victim)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state            <= ST_IDLE;
            flush_pending    <= 1'b0;
            cap_tag          <= '0;
            cap_idx          <= '0;
            cap_victim       <= '0;
            fill_req_valid_o <= 1'b0;
            tag_req_o        <= '0;
            tag_we_o         <= 1'b0;
            tag_vbit_o       <= 1'b0;
            tag_flush_o      <= 1'b0;
            busy_o           <= 1'b0;
            refill_done_o    <= 1'b0;
            refill_err_o     <= 1'b0;
        end else begin
            tag_req_o     <= '0;
            tag_we_o      <= 1'b0;
            tag_vbit_o    <= 1'b0;
            tag_flush_o   <= 1'b0;
            refill_done_o <= 1'b0;
            refill_err_o  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (flush_i) begin
                        state       <= ST_FLUSH;
                        tag_flush_o <= 1'b1;
                        busy_o      <= 1'b1;
                    end else if (miss_i) begin
                        cap_tag          <= miss_tag_i;
                        cap_idx          <= miss_idx_i;
                        cap_victim       <= sel_victim;
                        state            <= ST_REQ;
                        fill_req_valid_o <= 1'b1;
                        busy_o           <= 1'b1;
                    end
                end

                ST_REQ: begin
                    if (flush_i) begin
                        flush_pending <= 1'b1;
                    end
                    if (fill_req_ready_i) begin
                        fill_req_valid_o <= 1'b0;
                        state            <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (flush_i) begin
                        flush_pending <= 1'b1;
                    end
                    if (resp.valid) begin
                        if (!resp.err && !flush_now) begin
                            state         <= ST_WRITE;
                            tag_req_o     <= way_onehot;
                            tag_we_o      <= 1'b1;
                            tag_vbit_o    <= 1'b1;
                            refill_done_o <= 1'b1;
                        end else begin
                            refill_err_o <= resp.err;
                            if (flush_now) begin
                                state       <= ST_FLUSH;
                                tag_flush_o <= 1'b1;
                            end else begin
                                state  <= ST_IDLE;
                                busy_o <= 1'b0;
                            end
                        end
                    end
                end

                ST_WRITE: begin
                    if (flush_now) begin
                        flush_pending <= 1'b1;
                        state         <= ST_FLUSH;
                        tag_flush_o   <= 1'b1;
                    end else begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                    end
                end

                ST_FLUSH: begin
                    flush_pending <= 1'b0;
                    state         <= ST_IDLE;
                    busy_o        <= 1'b0;
                end

                default: begin
                    state            <= ST_IDLE;
                    flush_pending    <= 1'b0;
                    fill_req_valid_o <= 1'b0;
                    busy_o           <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Bench for icache_refill_ctrl: directed scenarios with literal expectations,
// then randomized traffic against a transaction-level reference model.
module tb_icache_refill_ctrl;

    localparam int TW = 20;
    localparam int IW = 8;
    localparam int W  = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           miss;
    logic [TW-1:0]  miss_tag;
    logic [IW-1:0]  miss_idx;
    logic [W-1:0]   vbits;
    logic           flush;
    logic           ready;
    logic           resp_valid;
    logic           resp_err;

    logic              fill_req_valid_o;
    logic [TW+IW-1:0]  fill_req_addr_o;
    logic [W-1:0]      tag_req_o;
    logic              tag_we_o;
    logic              tag_vbit_o;
    logic [TW-1:0]     tag_data_o;
    logic [IW-1:0]     tag_addr_o;
    logic              tag_flush_o;
    logic              busy_o;
    logic              refill_done_o;
    logic              refill_err_o;
    logic [1:0]        victim_way_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    icache_refill_ctrl #(.TAG_WIDTH(TW), .IDX_WIDTH(IW), .WAYS(W)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .miss_i            (miss),
        .miss_tag_i        (miss_tag),
        .miss_idx_i        (miss_idx),
        .way_vbits_i       (vbits),
        .flush_i           (flush),
        .fill_req_valid_o  (fill_req_valid_o),
        .fill_req_ready_i  (ready),
        .fill_req_addr_o   (fill_req_addr_o),
        .fill_resp_valid_i (resp_valid),
        .fill_resp_err_i   (resp_err),
        .tag_req_o         (tag_req_o),
        .tag_we_o          (tag_we_o),
        .tag_vbit_o        (tag_vbit_o),
        .tag_data_o        (tag_data_o),
        .tag_addr_o        (tag_addr_o),
        .tag_flush_o       (tag_flush_o),
        .busy_o            (busy_o),
        .refill_done_o     (refill_done_o),
        .refill_err_o      (refill_err_o),
        .victim_way_o      (victim_way_o)
    );

    // Reference model: where the refill transaction currently is, plus what it captured.
    localparam int P_IDLE  = 0;
    localparam int P_REQ   = 1;
    localparam int P_WAIT  = 2;
    localparam int P_WRITE = 3;
    localparam int P_FLUSH = 4;

    int            ph;
    logic [TW-1:0] m_tag;
    logic [IW-1:0] m_idx;
    int            m_victim;
    int            m_rr;
    bit            m_pend;
    bit            m_errp;

    function automatic int choose_victim(input logic [W-1:0] vb, input int rr);
        for (int i = 0; i < W; i++) begin
            if (!vb[i]) return i;
        end
        return rr;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph <= P_IDLE; m_tag <= '0; m_idx <= '0; m_victim <= 0;
            m_rr <= 0; m_pend <= 1'b0; m_errp <= 1'b0;
        end else begin
            m_errp <= 1'b0;
            case (ph)
                P_IDLE: begin
                    if (flush) ph <= P_FLUSH;
                    else if (miss) begin
                        m_tag    <= miss_tag;
                        m_idx    <= miss_idx;
                        m_victim <= choose_victim(vbits, m_rr);
                        if (&vbits) m_rr <= (m_rr + 1) % W;
                        ph <= P_REQ;
                    end
                end
                P_REQ: begin
                    if (flush) m_pend <= 1'b1;
                    if (ready) ph <= P_WAIT;
                end
                P_WAIT: begin
                    if (flush) m_pend <= 1'b1;
                    if (resp_valid) begin
                        m_errp <= resp_err;
                        if (!resp_err && !(m_pend || flush)) ph <= P_WRITE;
                        else if (m_pend || flush)            ph <= P_FLUSH;
                        else                                 ph <= P_IDLE;
                    end
                end
                P_WRITE: begin
                    if (m_pend || flush) begin m_pend <= 1'b1; ph <= P_FLUSH; end
                    else ph <= P_IDLE;
                end
                default: begin
                    m_pend <= 1'b0;
                    ph     <= P_IDLE;
                end
            endcase
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        bit wr;
        wr = (ph == P_WRITE);
        chk("busy",           64'(busy_o),           64'(ph != P_IDLE));
        chk("fill_req_valid", 64'(fill_req_valid_o), 64'(ph == P_REQ));
        chk("fill_req_addr",  64'(fill_req_addr_o),  64'({m_tag, m_idx}));
        chk("tag_req",        64'(tag_req_o),        wr ? (64'(1) << m_victim) : 64'(0));
        chk("tag_we",         64'(tag_we_o),         64'(wr));
        chk("tag_vbit",       64'(tag_vbit_o),       64'(wr));
        chk("refill_done",    64'(refill_done_o),    64'(wr));
        chk("tag_flush",      64'(tag_flush_o),      64'(ph == P_FLUSH));
        chk("refill_err",     64'(refill_err_o),     64'(m_errp));
        chk("tag_data",       64'(tag_data_o),       64'(m_tag));
        chk("tag_addr",       64'(tag_addr_o),       64'(m_idx));
        chk("victim_way",     64'(victim_way_o),     64'(m_victim));
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        compare_model();
    endtask

    task automatic idle_inputs();
        miss = 1'b0; flush = 1'b0; resp_valid = 1'b0; resp_err = 1'b0;
    endtask

    task automatic drain(input string nm);
        idle_inputs();
        ready = 1'b1; resp_valid = 1'b1;
        for (int i = 0; i < 20 && ph != P_IDLE; i++) cyc();
        resp_valid = 1'b0;
        cyc();
        chk(nm, 64'(busy_o), 64'(0));
    endtask

    initial begin
        rst = 1'b1; idle_inputs(); ready = 1'b0;
        miss_tag = '0; miss_idx = '0; vbits = '0;
        #1;
        chk("rst_busy",   64'(busy_o), 64'(0));
        chk("rst_valid",  64'(fill_req_valid_o), 64'(0));
        chk("rst_addr",   64'(fill_req_addr_o), 64'(0));
        chk("rst_flush",  64'(tag_flush_o), 64'(0));
        chk("rst_victim", 64'(victim_way_o), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Basic refill with a free way
        miss = 1'b1; miss_tag = 20'hABCDE; miss_idx = 8'h12; vbits = 4'b1011; ready = 1'b1;
        cyc();
        miss = 1'b0;
        chk("d18_valid", 64'(fill_req_valid_o), 64'(1));
        chk("d18_addr",  64'(fill_req_addr_o), 64'h0ABCDE12);
        chk("d18_vict",  64'(victim_way_o), 64'(2));
        cyc();
        chk("d18_nodone_c2", 64'(refill_done_o), 64'(0));
        resp_valid = 1'b1;
        cyc();
        resp_valid = 1'b0;
        chk("d18_tag_req",  64'(tag_req_o), 64'b0100);
        chk("d18_tag_data", 64'(tag_data_o), 64'hABCDE);
        chk("d18_tag_addr", 64'(tag_addr_o), 64'h12);
        chk("d18_done_c3",  64'(refill_done_o), 64'(1));
        cyc();
        chk("d18_idle", 64'(busy_o), 64'(0));

        // Round-robin on full sets
        for (int k = 0; k < 5; k++) begin
            miss = 1'b1; miss_tag = TW'(k + 1); miss_idx = IW'(k); vbits = 4'b1111;
            cyc();
            miss = 1'b0;
            chk("d19_victim", 64'(victim_way_o), 64'(k % 4));
            cyc();
            resp_valid = 1'b1;
            cyc();
            resp_valid = 1'b0;
            chk("d19_tag_req", 64'(tag_req_o), 64'(1) << (k % 4));
            cyc();
        end

        // Backpressure on the request
        ready = 1'b0;
        miss = 1'b1; miss_tag = 20'h13579; miss_idx = 8'h5A; vbits = 4'b0000;
        cyc();
        miss = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("d20_valid", 64'(fill_req_valid_o), 64'(1));
            chk("d20_addr",  64'(fill_req_addr_o), 64'h135795A);
            cyc();
        end
        chk("d20_still_req", 64'(fill_req_valid_o), 64'(1));
        ready = 1'b1;
        cyc();
        chk("d20_accepted", 64'(fill_req_valid_o), 64'(0));
        resp_valid = 1'b1;
        cyc();
        resp_valid = 1'b0;
        cyc();

        // Flush during WAIT blocks the tag write
        miss = 1'b1; miss_tag = 20'h0F0F0; miss_idx = 8'h33; vbits = 4'b0001;
        cyc();
        miss = 1'b0;
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        resp_valid = 1'b1;
        cyc();
        resp_valid = 1'b0;
        chk("d21_no_we",  64'(tag_we_o), 64'(0));
        chk("d21_flush",  64'(tag_flush_o), 64'(1));
        cyc();
        chk("d21_flush_once", 64'(tag_flush_o), 64'(0));
        chk("d21_not_busy",   64'(busy_o), 64'(0));

        // Error response
        miss = 1'b1; miss_tag = 20'h55555; miss_idx = 8'hAA; vbits = 4'b0000;
        cyc();
        miss = 1'b0;
        cyc();
        resp_valid = 1'b1; resp_err = 1'b1;
        cyc();
        resp_valid = 1'b0; resp_err = 1'b0;
        chk("d22_err",   64'(refill_err_o), 64'(1));
        chk("d22_no_we", 64'(tag_we_o), 64'(0));
        chk("d22_idle",  64'(busy_o), 64'(0));
        cyc();
        chk("d22_err_once", 64'(refill_err_o), 64'(0));

        // Flush and miss together in IDLE
        flush = 1'b1; miss = 1'b1;
        cyc();
        flush = 1'b0; miss = 1'b0;
        chk("d22b_flush",    64'(tag_flush_o), 64'(1));
        chk("d22b_no_req",   64'(fill_req_valid_o), 64'(0));
        cyc();
        chk("d22b_no_req2",  64'(fill_req_valid_o), 64'(0));

        // Reset in WAIT
        miss = 1'b1; miss_tag = 20'hFEDCB; miss_idx = 8'h77; vbits = 4'b0000;
        cyc();
        miss = 1'b0;
        cyc();
        #1 rst = 1'b1;
        #1;
        chk("d23_busy",  64'(busy_o), 64'(0));
        chk("d23_addr",  64'(fill_req_addr_o), 64'(0));
        chk("d23_data",  64'(tag_data_o), 64'(0));
        chk("d23_valid", 64'(fill_req_valid_o), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        resp_valid = 1'b1;
        cyc();
        resp_valid = 1'b0;
        chk("d23_no_we",   64'(tag_we_o), 64'(0));
        chk("d23_no_done", 64'(refill_done_o), 64'(0));
        cyc();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            miss       = ($urandom_range(0, 3) == 0);
            miss_tag   = TW'($urandom);
            miss_idx   = IW'($urandom);
            vbits      = ($urandom_range(0, 2) == 0) ? 4'hF : W'($urandom);
            flush      = ($urandom_range(0, 19) == 0);
            ready      = ($urandom_range(0, 9) < 6);
            resp_valid = ($urandom_range(0, 9) < 3);
            resp_err   = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1'b1;
                cyc();
                rst = 1'b0;
            end else begin
                cyc();
            end
        end

        drain("drain_busy");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/icache_refill_ctrl.md
ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

Interface
REQ-001 SHALL take parameters: TAG_WIDTH, default 20, tag bits per line; IDX_WIDTH, default 8, set-index bits; WAYS, default 4, associativity (power of two).
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- miss_i  in  1  lookup miss valid (one-cycle pulse).
- miss_tag_i  in  TAG_WIDTH  tag of missing line.
- miss_idx_i  in  IDX_WIDTH  set index of missing line.
- way_vbits_i  in  WAYS  valid bits of the set at miss_idx_i, sampled with miss_i.
- flush_i  in  1  invalidate-all request (pulse).
- fill_req_valid_o  out  1  line-fill request valid.
- fill_req_ready_i  in  1  downstream accepts request.
- fill_req_addr_o  out  TAG_WIDTH+IDX_WIDTH  line address {tag,idx}.
- fill_resp_valid_i  in  1  fill response arrives (one-cycle pulse).
- fill_resp_err_i  in  1  response carries bus error; qualified by fill_resp_valid_i.
- tag_req_o  out  WAYS  per-way tag memory request.
- tag_we_o  out  1  tag memory write enable.
- tag_vbit_o  out  1  valid bit to write.
- tag_data_o  out  TAG_WIDTH  tag to write.
- tag_addr_o  out  IDX_WIDTH  tag memory index.
- tag_flush_o  out  1  clears all valid bits in every way.
- busy_o  out  1  high whenever state is not IDLE.
- refill_done_o  out  1  one-cycle pulse on successful tag write.
- refill_err_o  out  1  one-cycle pulse on erroneous response.
- victim_way_o  out  log2(WAYS)  way being refilled, stable from REQ through WRITE.

Function
REQ-003 SHALL implement FSM states IDLE, REQ, WAIT, WRITE and FLUSH.
REQ-004 IDLE: if flush_i, go to FLUSH and ignore any simultaneous miss_i. Else if miss_i, capture tag, idx and victim, then go to REQ.
REQ-005 Victim selection: lowest-numbered way with way_vbits_i bit = 0. If all ways are valid, use the round-robin counter value. The counter increments (wrapping) only when it is used.
REQ-006 REQ: fill_req_valid_o = 1 and fill_req_addr_o = {captured tag, captured idx}, both held stable until fill_req_ready_i. Transfer on valid&ready, then go to WAIT.
REQ-007 WAIT: on fill_resp_valid_i, go to WRITE if resp_err = 0 and no flush is pending; otherwise pulse refill_err_o (if err) and go to FLUSH (if flush pending) or IDLE.
REQ-008 WRITE (exactly one cycle): tag_req_o is one-hot at the victim way, tag_we_o = 1, tag_vbit_o = 1, tag_data_o = captured tag, tag_addr_o = captured idx, refill_done_o = 1. Next state: FLUSH if a flush is pending, else IDLE.
REQ-009 flush_i arriving in REQ, WAIT or WRITE SHALL set flush_pending. An outstanding request SHALL complete its handshake. A response received after flush_i SHALL NOT write a tag.
REQ-010 FLUSH (exactly one cycle): tag_flush_o = 1, clear flush_pending, go to IDLE.
REQ-011 miss_i outside IDLE SHALL be ignored; the requester re-issues it.
REQ-012 Outside WRITE, tag_req_o, tag_we_o and tag_vbit_o SHALL be 0. tag_data_o and tag_addr_o hold the captured values.
REQ-013 Minimum latency from miss_i to refill_done_o SHALL be 3 cycles, given ready in REQ and response on the first WAIT cycle.

Reset
REQ-014 When rst_i is asserted, the block SHALL immediately and asynchronously go to IDLE, with round-robin counter = 0, flush_pending = 0, captured tag/idx/victim = 0, and every output = 0.
REQ-015 Reset mid-operation SHALL abandon any outstanding request without issuing a tag write or a flush pulse.

Structure
REQ-016 The following SHALL live in the shared icache package: TAG_WIDTH, IDX_WIDTH and WAYS defaults, the FSM state enum, and the fill request/response struct types.
REQ-017 Victim selection (priority encoder plus round-robin counter) SHALL be one sub-module, icache_victim_sel. The FSM and datapath SHALL stay in this module.

Verification
REQ-018 Miss with tag 0xABCDE, idx 0x12, vbits 4'b1011, ready high, response without error on the first WAIT cycle: fill_req_addr_o = 0xABCDE12; one WRITE cycle with tag_req_o = 4'b0100, tag_data_o = 0xABCDE, tag_addr_o = 0x12; refill_done_o 3 cycles after miss_i.
REQ-019 Four back-to-back misses, each with vbits 4'b1111: victims 0, 1, 2, 3, then wrap to 0 on a fifth miss.
REQ-020 fill_req_ready_i held low for 5 cycles: fill_req_valid_o and fill_req_addr_o are stable throughout; the FSM stays in REQ.
REQ-021 flush_i during WAIT, followed by a response: no tag write, one tag_flush_o pulse, busy_o deasserts afterwards.
REQ-022 Response with fill_resp_err_i = 1: refill_err_o pulses, no tag write, return to IDLE. Separately, flush_i and miss_i asserted together in IDLE: flush only, no fill request.
REQ-023 rst_i asserted in WAIT: all outputs 0 immediately. A later fill_resp_valid_i has no effect.
